riscv_cpu: RTL and testbench

- Minimal RV32I integer execute core. Executes externally supplied OP-IMM (opcode 0010011) and OP (opcode 0110011) instructions against an internal 32x32 register file.
- No fetch, PC, memory or branch logic. An instruction word is presented on a port with a ready strobe and retires in a single clock.
- Sits under the system controller, which acts as the instruction source. Verification observes state through the write-back and debug ports.

---
 rtl/riscv_cpu_if.sv | 33 +++
 rtl/riscv_cpu.sv | 119 +++++++++++
 tb/tb_riscv_cpu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/riscv_cpu_if.sv
// Instruction/write-back/debug bundle between the system controller and riscv_cpu.
// Optional retire counter port exists only when RISCV_CPU_RETIRE_CNT_EN is defined.
interface riscv_cpu_if;
    logic [31:0] cpu_instruction;
    logic        cpu_instruction_RDY_BSY;
    logic [4:0]  cpu_dbg_addr;
    logic [31:0] cpu_dbg_data;
    logic        cpu_wb_valid;
    logic [4:0]  cpu_wb_rd;
    logic [31:0] cpu_wb_data;
    logic        cpu_illegal;
`ifdef RISCV_CPU_RETIRE_CNT_EN
    logic [31:0] cpu_retire_cnt;
`endif

    // Instruction source / observer side (system controller, testbench)
    modport master (
        output cpu_instruction, cpu_instruction_RDY_BSY, cpu_dbg_addr,
        input  cpu_dbg_data, cpu_wb_valid, cpu_wb_rd, cpu_wb_data, cpu_illegal
`ifdef RISCV_CPU_RETIRE_CNT_EN
        , input cpu_retire_cnt
`endif
    );

    // Core side
    modport slave (
        input  cpu_instruction, cpu_instruction_RDY_BSY, cpu_dbg_addr,
        output cpu_dbg_data, cpu_wb_valid, cpu_wb_rd, cpu_wb_data, cpu_illegal
`ifdef RISCV_CPU_RETIRE_CNT_EN
        , output cpu_retire_cnt
`endif
    );
endinterface

// File: rtl/riscv_cpu.sv
// Minimal RV32I execute core: OP-IMM and OP instructions retire in one clock
// against a 32x32 register file. x0 is hardwired to zero.
// Optional feature macro: RISCV_CPU_RETIRE_CNT_EN adds a 32-bit retire counter.
module riscv_cpu #(
    parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
    input  logic      cpu_clk,
    input  logic      cpu_rst,
    riscv_cpu_if.slave bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0][31:0] rf;

    logic [31:0] inst;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  funct3;
    logic [31:0] imm, a, b, result;
    logic        legal;

    assign inst   = bus.cpu_instruction;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign imm    = {{20{inst[31]}}, inst[31:20]};

    // Operand reads see the current register state; x0 always reads zero
    assign a = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign b = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign bus.cpu_dbg_data = (bus.cpu_dbg_addr == 5'd0) ? 32'd0 : rf[bus.cpu_dbg_addr];

    // Decode and execute; shift-immediates with a bad upper field are illegal
    always_comb begin
        result = 32'd0;
        legal  = 1'b0;
        shamt  = 5'd0;
        case (opcode)
            OPC_OP_IMM: begin
                legal = 1'b1;
                shamt = imm[4:0];
                case (funct3)
                    3'b000: result = a + imm;
                    3'b010: result = {31'd0, $signed(a) < $signed(imm)};
                    3'b011: result = {31'd0, a < imm};
                    3'b100: result = a ^ imm;
                    3'b110: result = a | imm;
                    3'b111: result = a & imm;
                    3'b001: begin
                        legal  = (funct7 == 7'b0000000);
                        result = a << shamt;
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      result = a >> shamt;
                        else if (funct7 == 7'b0100000) result = $signed(a) >>> shamt;
                        else                           legal  = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                legal = 1'b1;
                shamt = b[4:0];
                case (funct3)
                    3'b000:  result = funct7[5] ? a - b : a + b;
                    3'b001:  result = a << shamt;
                    3'b010:  result = {31'd0, $signed(a) < $signed(b)};
                    3'b011:  result = {31'd0, a < b};
                    3'b100:  result = a ^ b;
                    3'b101:  result = funct7[5] ? $signed(a) >>> shamt : a >> shamt;
                    3'b110:  result = a | b;
                    default: result = a & b;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

`ifdef RISCV_CPU_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    assign bus.cpu_retire_cnt = retire_cnt;
`endif

    // Retire: register write, write-back pulse, illegal pulse; reset wins over a presented word
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rf[0] <= 32'd0;
            for (int i = 1; i < 32; i++) rf[i] <= REG_RESET_VAL;
            bus.cpu_wb_valid <= 1'b0;
            bus.cpu_wb_rd    <= 5'd0;
            bus.cpu_wb_data  <= 32'd0;
            bus.cpu_illegal  <= 1'b0;
`ifdef RISCV_CPU_RETIRE_CNT_EN
            retire_cnt       <= 32'd0;
`endif
        end else begin
            bus.cpu_wb_valid <= 1'b0;
            bus.cpu_illegal  <= 1'b0;
            if (bus.cpu_instruction_RDY_BSY) begin
                if (!legal) begin
                    bus.cpu_illegal <= 1'b1;
                end else begin
`ifdef RISCV_CPU_RETIRE_CNT_EN
                    retire_cnt <= retire_cnt + 32'd1;
`endif
                    if (rd != 5'd0) begin
                        rf[rd]           <= result;
                        bus.cpu_wb_valid <= 1'b1;
                        bus.cpu_wb_rd    <= rd;
                        bus.cpu_wb_data  <= result;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_cpu.sv
// Scoreboard bench for riscv_cpu: stimulus pushes the expected retire event,
// a monitor pops and compares on every wb_valid/illegal pulse.
// Define RISCV_CPU_RETIRE_CNT_EN to also exercise the retire counter.
module tb_riscv_cpu;
    localparam logic [31:0] RV = 32'h1234_5678;

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    riscv_cpu_if bus();

    riscv_cpu #(.REG_RESET_VAL(RV)) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input logic [4:0] idx, input logic [31:0] exp);
        bus.cpu_dbg_addr = idx;
        #1;
        check($sformatf("x%0d", idx), bus.cpu_dbg_data, exp);
    endtask

    task automatic issue(input logic [31:0] ins, input logic rdy, input logic push,
                         input logic ill, input logic [4:0] rd, input logic [31:0] data);
        bus.cpu_instruction         = ins;
        bus.cpu_instruction_RDY_BSY = rdy;
        if (push) sb.push_back('{ill: ill, rd: rd, data: data});
        @(posedge clk);
        #1;
        bus.cpu_instruction_RDY_BSY = 1'b0;
    endtask

    task automatic wb(input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] data);
        issue(ins, 1'b1, 1'b1, 1'b0, rd, data);
    endtask

    task automatic ill(input logic [31:0] ins);
        issue(ins, 1'b1, 1'b1, 1'b1, 5'd0, 32'd0);
    endtask

    // Monitor: every output pulse must match the oldest expected event
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cpu_wb_valid || bus.cpu_illegal) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, bus.cpu_wb_valid, bus.cpu_illegal}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_illegal", {31'd0, bus.cpu_illegal}, {31'd0, e.ill});
                    check("mon_wb_valid", {31'd0, bus.cpu_wb_valid}, {31'd0, !e.ill});
                    if (!e.ill) begin
                        check("mon_wb_rd", {27'd0, bus.cpu_wb_rd}, {27'd0, e.rd});
                        check("mon_wb_data", bus.cpu_wb_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cpu_instruction         = 32'd0;
        bus.cpu_instruction_RDY_BSY = 1'b0;
        bus.cpu_dbg_addr            = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_wb_valid", {31'd0, bus.cpu_wb_valid}, 32'd0);
        check("rst_illegal", {31'd0, bus.cpu_illegal}, 32'd0);
        check("rst_wb_rd", {27'd0, bus.cpu_wb_rd}, 32'd0);
        check("rst_wb_data", bus.cpu_wb_data, 32'd0);
        check_reg(5'd0, 32'd0);
        check_reg(5'd1, RV);
        check_reg(5'd31, RV);
`ifdef RISCV_CPU_RETIRE_CNT_EN
        check("rst_cnt", bus.cpu_retire_cnt, 32'd0);
`endif

        // Held ADDI x1,x0,5 and dependent ADDI x2,x1,5
        for (int i = 0; i < 10; i++) begin
            wb(32'h00500093, 5'd1, 32'd5);
            check_reg(5'd1, 32'd5);
        end
        for (int i = 0; i < 11; i++) begin
            wb(32'h00508113, 5'd2, 32'd10);
            check_reg(5'd2, 32'd10);
        end
        wb(32'h002001B3, 5'd3, 32'd10);              // ADD x3,x0,x2
        check_reg(5'd3, 32'd10);

        // Idle with a garbage word: nothing retires, wb_rd/wb_data hold
        issue(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("idle_wb_valid", {31'd0, bus.cpu_wb_valid}, 32'd0);
        check("idle_illegal", {31'd0, bus.cpu_illegal}, 32'd0);
        check("idle_wb_rd", {27'd0, bus.cpu_wb_rd}, 32'd3);
        check("idle_wb_data", bus.cpu_wb_data, 32'd10);
        check_reg(5'd1, 32'd5);
        check_reg(5'd2, 32'd10);

        // Write to x0 is silent; load opcode is illegal
        issue(32'h00700013, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);   // ADDI x0,x0,7
        check("x0w_wb_valid", {31'd0, bus.cpu_wb_valid}, 32'd0);
        check("x0w_illegal", {31'd0, bus.cpu_illegal}, 32'd0);
        check_reg(5'd0, 32'd0);
        ill(32'h0000A403);                                    // LW x8,0(x1)
        check_reg(5'd8, RV);

        // Arithmetic, shifts, compares
        wb(32'hFF000213, 5'd4, 32'hFFFF_FFF0);       // ADDI x4,x0,-16
        wb(32'h40225293, 5'd5, 32'hFFFF_FFFC);       // SRAI x5,x4,2
        wb(32'h00225293, 5'd5, 32'h3FFF_FFFC);       // SRLI x5,x4,2
        ill(32'h20225293);                           // shift-imm, bad upper field
        check_reg(5'd5, 32'h3FFF_FFFC);
        wb(32'h40400333, 5'd6, 32'd16);              // SUB x6,x0,x4
        wb(32'h004033B3, 5'd7, 32'd1);               // SLTU x7,x0,x4
        wb(32'h000223B3, 5'd7, 32'd1);               // SLT x7,x4,x0
        wb(32'hFFF03493, 5'd9, 32'd1);               // SLTIU x9,x0,-1
        wb(32'h404245B3, 5'd11, 32'd0);              // XOR x11,x4,x4 (funct7 ignored)
        wb(32'h0FF27613, 5'd12, 32'h0000_00F0);      // ANDI x12,x4,0xFF
        wb(32'h001216B3, 5'd13, 32'hFFFF_FE00);      // SLL x13,x4,x1
        check_reg(5'd6, 32'd16);
        check_reg(5'd13, 32'hFFFF_FE00);

        // Reset overrides a presented valid instruction
        rst = 1'b1;
        issue(32'h00500093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        check("rst2_wb_valid", {31'd0, bus.cpu_wb_valid}, 32'd0);
        check("rst2_wb_rd", {27'd0, bus.cpu_wb_rd}, 32'd0);
        check("rst2_wb_data", bus.cpu_wb_data, 32'd0);
        check_reg(5'd0, 32'd0);
        for (int r = 1; r < 32; r++) check_reg(r[4:0], RV);

`ifdef RISCV_CPU_RETIRE_CNT_EN
        check("rst2_cnt", bus.cpu_retire_cnt, 32'd0);
        wb(32'h00500093, 5'd1, 32'd5);
        issue(32'h00700013, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        ill(32'h0000A403);
        wb(32'h002001B3, 5'd3, RV);
        check("cnt3", bus.cpu_retire_cnt, 32'd3);
`endif

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
